// File: rtl/concat_seq_ctrl_pkg.sv
// concat_seq_pkg: shared state encoding, mode constants and default widths for concat_seq_ctrl
package concat_seq_pkg;
  typedef enum logic {COLLECT, HOLD} state_t;
  localparam logic MODE_CAT = 1'b0;
  localparam logic MODE_REP = 1'b1;
  localparam int NIB_W_DEF = 4;
  localparam int NUM_NIB_DEF = 3;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/concat_seq_ctrl_if.sv
// concat_seq_ctrl_if: nibble-in / word-out handshake bundle; master drives nibbles and out_ready, slave is the sequencer
interface concat_seq_ctrl_if #(
  parameter int NIB_W = concat_seq_pkg::NIB_W_DEF,
  parameter int NUM_NIB = concat_seq_pkg::NUM_NIB_DEF,
  parameter int CNT_W = concat_seq_pkg::CNT_W_DEF
);
  logic mode_in;
  logic in_valid;
  logic in_ready;
  logic [NIB_W-1:0] in_nib;
  logic out_valid;
  logic out_ready;
  logic [NIB_W*NUM_NIB-1:0] out_word;
  logic [CNT_W-1:0] word_count;
  modport master (
    output mode_in, in_valid, in_nib, out_ready,
    input in_ready, out_valid, out_word, word_count
  );
  modport slave (
    input mode_in, in_valid, in_nib, out_ready,
    output in_ready, out_valid, out_word, word_count
  );
endinterface

// File: rtl/concat_seq_ctrl.sv
// concat_seq_ctrl: assembles NUM_NIB nibbles (concat) or one replicated nibble into a word with valid/ready output and a word counter
// Ports: clk, rst (sync active-high); bus (concat_seq_ctrl_if.slave): mode_in/in_valid/in_ready/in_nib in, out_valid/out_ready/out_word/word_count out.
// Build option: REPL_MODE_EN enables replicate mode; without it mode_in is ignored and every word is a concatenation.
module concat_seq_ctrl import concat_seq_pkg::*; #(
  parameter int NIB_W = NIB_W_DEF,
  parameter int NUM_NIB = NUM_NIB_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  concat_seq_ctrl_if.slave bus
);
  localparam int W = NIB_W*NUM_NIB;
  localparam int IDX_W = NUM_NIB > 1 ? $clog2(NUM_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NIB-1);
  state_t r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [W-1:0] r_word, w_word_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic r_mode, w_mode_in, w_mode, w_rep, w_last, w_in_fire, w_out_fire;
`ifdef REPL_MODE_EN
  assign w_mode_in = bus.mode_in;
`else
  logic w_unused_mode;
  assign w_unused_mode = bus.mode_in;
  assign w_mode_in = MODE_CAT;
`endif
  assign bus.in_ready = r_state == COLLECT;
  assign bus.out_valid = r_state == HOLD;
  assign bus.out_word = r_word;
  assign bus.word_count = r_cnt;
  assign w_in_fire = bus.in_valid & bus.in_ready;
  assign w_out_fire = bus.out_valid & bus.out_ready;
  // mode is live on the first nibble and latched for the rest of the word
  assign w_mode = r_idx == '0 ? w_mode_in : r_mode;
  assign w_rep = w_mode == MODE_REP;
  assign w_last = w_rep || r_idx == LAST;
  always_ff @(posedge clk)
    if (rst) r_state <= COLLECT;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state == COLLECT ? (w_in_fire && w_last ? HOLD : COLLECT)
                                     : (w_out_fire ? COLLECT : HOLD);
    w_idx_nxt = w_in_fire ? (w_last ? '0 : r_idx + 1'b1) : r_idx;
  end
  // slot 0 is the MSB nibble; replicate writes every slot so nothing stale survives
  always_comb begin
    w_word_nxt = r_word;
    for (int i = 0; i < NUM_NIB; i++)
      if (w_in_fire && (w_rep || i == int'(r_idx)))
        w_word_nxt[NIB_W*(NUM_NIB-i)-1 -: NIB_W] = bus.in_nib;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_idx <= '0;
      r_word <= '0;
      r_mode <= MODE_CAT;
      r_cnt <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      r_word <= w_word_nxt;
      if (w_in_fire && r_idx == '0) r_mode <= w_mode_in;
      if (w_out_fire) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_concat_seq_ctrl.sv
// tb_concat_seq_ctrl: directed self-checking bench for concat_seq_ctrl
module tb_concat_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  concat_seq_ctrl_if bus ();
  concat_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [3:0] nib, input logic mode);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_nib = nib;
    bus.mode_in = mode;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mode_in = ~mode;
    bus.in_nib = 4'hD;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic word_chk(input string tag, input logic [11:0] exp, input logic [7:0] cnt);
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_word"}, bus.out_word, exp);
    chk({tag, "_inrdy"}, bus.in_ready, 1'b0);
    @(negedge clk);
    chk({tag, "_done"}, bus.out_valid, 1'b0);
    chk({tag, "_cnt"}, bus.word_count, cnt);
  endtask
  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_nib = 4'h0;
    bus.mode_in = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_inrdy", bus.in_ready, 1'b1);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_word", bus.out_word, 12'h000);
    chk("rst_cnt", bus.word_count, 8'd0);
    send(4'hF, 1'b0); send(4'hB, 1'b0); send(4'h0, 1'b0);
    word_chk("cat", 12'hFB0, 8'd1);
`ifdef REPL_MODE_EN
    send(4'hA, 1'b1);
    word_chk("rep", 12'hAAA, 8'd2);
`else
    send(4'hA, 1'b1); send(4'hE, 1'b0); send(4'hE, 1'b0);
    word_chk("rep_off", 12'hAEE, 8'd2);
`endif
    bus.out_ready = 1'b0;
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_word", bus.out_word, 12'h123);
      chk("bp_inrdy", bus.in_ready, 1'b0);
      chk("bp_cnt", bus.word_count, 8'd2);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", bus.out_valid, 1'b0);
    chk("bp_cnt_after", bus.word_count, 8'd3);
    send(4'h4, 1'b0); send(4'h5, 1'b1); send(4'h6, 1'b1);
    word_chk("latch", 12'h456, 8'd4);
    send(4'h7, 1'b0);
    idle(3);
    chk("gap_valid", bus.out_valid, 1'b0);
    send(4'h8, 1'b1);
    idle(2);
    chk("gap_inrdy", bus.in_ready, 1'b1);
    send(4'h9, 1'b1);
    word_chk("gap", 12'h789, 8'd5);
    send(4'h5, 1'b0); send(4'h6, 1'b0);
    pulse_rst();
    chk("mid_rst_cnt", bus.word_count, 8'd0);
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_word", bus.out_word, 12'h000);
    send(4'h7, 1'b0); send(4'h8, 1'b0); send(4'h9, 1'b0);
    word_chk("after_rst", 12'h789, 8'd1);
    bus.out_ready = 1'b0;
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0);
    chk("hold_valid", bus.out_valid, 1'b1);
    pulse_rst();
    bus.out_ready = 1'b1;
    chk("hold_rst_cnt", bus.word_count, 8'd0);
    chk("hold_rst_valid", bus.out_valid, 1'b0);
    for (int w = 0; w < 256; w++) begin
`ifdef REPL_MODE_EN
      send(4'(w), 1'b1);
      if (w == 3) chk("wrap_word", bus.out_word, 12'h333);
`else
      send(4'(w), 1'b1); send(4'h0, 1'b1); send(4'hC, 1'b1);
      if (w == 3) chk("wrap_word", bus.out_word, 12'h30C);
`endif
      @(negedge clk);
      if (w == 254) chk("wrap_255", bus.word_count, 8'd255);
    end
    chk("wrap_0", bus.word_count, 8'd0);
    chk("wrap_inrdy", bus.in_ready, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/concat_seq_ctrl.md
Name: concat_seq_ctrl

Overview:
Sequencer in front of the 4-bit concatenation/replication datapath. Accepts a stream of nibbles over a valid/ready handshake and assembles them into one 12-bit word. The word is either the concatenation {a,b,c} of three nibbles or the replication {3{n}} of one nibble. The assembled word is presented on a valid/ready output and a completed-word counter is kept.

Parameters:
NIB_W, 4, width of one input nibble
NUM_NIB, 3, nibbles per concatenated word; output width is NIB_W*NUM_NIB
CNT_W, 8, width of the completed-word counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
mode_in  input  1  0 = concatenate NUM_NIB nibbles, 1 = replicate one nibble; sampled only on the first nibble of a word
in_valid  input  1  in_nib is valid
in_ready  output  1  block can accept a nibble this cycle
in_nib  input  NIB_W  nibble data, first accepted nibble lands in the MSB slot
out_valid  output  1  out_word holds a completed word
out_ready  input  1  consumer accepts out_word
out_word  output  NIB_W*NUM_NIB  assembled word
word_count  output  CNT_W  number of words handed off since reset

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=COLLECT, slot index=0, out_valid=0, out_word=0, word_count=0, latched mode=0. in_ready=1 in the first cycle after reset.
- An input transfer happens when in_valid and in_ready are both high on a rising edge. An output transfer happens when out_valid and out_ready are both high.
- State COLLECT:
  - in_ready=1 and out_valid=0.
  - On each input transfer, the nibble is written to slot idx, where slot 0 = bits [NIB_W*NUM_NIB-1 -: NIB_W] (MSB).
  - The transfer at idx=0 also latches mode_in. mode_in is ignored at any other time.
  - Concat mode: idx increments on each transfer. The transfer at idx=NUM_NIB-1 moves the state to HOLD and resets idx to 0.
  - Replicate mode: the transfer at idx=0 writes the nibble to every slot and moves the state to HOLD directly.
- State HOLD:
  - in_ready=0, out_valid=1, out_word is stable.
  - An output transfer increments word_count (wrapping 2^CNT_W-1 -> 0) and returns the state to COLLECT on the next cycle.
- Latency and throughput:
  - out_valid rises the cycle after the last nibble transfer. There is no combinational in->out path.
  - Peak throughput is one concat word per NUM_NIB+1 cycles and one replicate word per 2 cycles.
- Boundaries:
  - in_valid low mid-word: idx and partial data are held indefinitely.
  - out_ready held low: out_word and out_valid are held and nibbles are back-pressured (in_ready=0).
  - out_ready high while in COLLECT: ignored.
  - rst asserted mid-word or in HOLD: the partial or undelivered word is discarded, all reset values apply, and word_count is not incremented.
  - Unused slots never retain stale data after a replicate word, because all slots are overwritten.

Optional Feature:
REPL_MODE_EN.
- Defined: mode_in is honoured as described above.
- Undefined: the latched mode is forced to 0 (concat only) and mode_in is unused. A mode_in=1 stimulus produces a concat word.

Decomposition:
- Package concat_seq_pkg holds:
  - state enum {COLLECT, HOLD}
  - mode constants MODE_CAT=0 and MODE_REP=1
  - default width constants NIB_W_DEF=4, NUM_NIB_DEF=3
- No sub-module is needed. Slot write/replicate logic and the counter stay inline in one module.

Test Plan:
- Concat: after reset, send nibbles 0xF, 0xB, 0x0 with mode_in=0 and out_ready=1 -> out_word=0xFB0 with out_valid for 1 cycle, word_count=1.
- Replicate (REPL_MODE_EN defined): send 0xA with mode_in=1 -> out_word=0xAAA the next cycle. With the macro undefined, send 0xA, 0xE, 0xE -> out_word=0xAEE.
- Backpressure: hold out_ready=0 for 5 cycles after 0x1, 0x2, 0x3 -> out_word=0x123 stable, in_ready=0 throughout, and one word delivered when out_ready rises.
- Mode latch: mode_in=0 on the first nibble, then toggle to 1 for the 2nd and 3rd -> still a concat word. Gapped in_valid -> same result.
- Reset mid-word: accept 0x5, 0x6, assert rst for 1 cycle, then send 0x7, 0x8, 0x9 -> out_word=0x789 and word_count=1.
- Counter wrap: deliver 256 replicate words -> word_count goes 255 -> 0.
